// File: rtl/mux4_1_pkg.sv
// Shared select encoding for the registered 4:1 lane multiplexer.
// Imported by the combinational selector and the top.
package mux4_1_pkg;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_LANE0 = 2'd0;
  localparam sel_t SEL_LANE1 = 2'd1;
  localparam sel_t SEL_LANE2 = 2'd2;
  localparam sel_t SEL_LANE3 = 2'd3;

endpackage

// File: rtl/mux4_1_comb.sv
// Pure combinational LANE_W-wide 4:1 select.
// Unknown selects fall through to an all-zero result.
module mux4_1_comb
  import mux4_1_pkg::*;
#(
  parameter int LANE_W = 1
) (
  input  logic [4*LANE_W-1:0] data,
  input  sel_t                sel,
  output logic [LANE_W-1:0]   y
);

  always_comb begin
    y = '0;
    case (sel)
      SEL_LANE0: y = data[0*LANE_W +: LANE_W];
      SEL_LANE1: y = data[1*LANE_W +: LANE_W];
      SEL_LANE2: y = data[2*LANE_W +: LANE_W];
      SEL_LANE3: y = data[3*LANE_W +: LANE_W];
      default:   y = '0;
    endcase
  end

endmodule

// File: rtl/mux4_1.sv
// Registered 4:1 multiplexer with a qualifying valid.
// Async active-low reset; release is synchronised by two flops.
module mux4_1
  import mux4_1_pkg::*;
#(
  parameter int LANE_W = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [4*LANE_W-1:0] data_in,
  input  sel_t                sel_in,
  input  logic                in_valid,
  output logic [LANE_W-1:0]   y_out,
  output logic                out_valid
);

  logic [1:0]        sync;
  logic              run;
  logic              take;
  logic [LANE_W-1:0] y_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[0], 1'b1};
    end
  end

  // Samples are honoured from the edge at which the second stage loads.
  assign run  = |sync;
  assign take = in_valid & run;

  mux4_1_comb #(
    .LANE_W(LANE_W)
  ) u_sel (
    .data(data_in),
    .sel (sel_in),
    .y   (y_sel)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_out     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= take;
      if (take) begin
        y_out <= y_sel;
      end
    end
  end

endmodule

// File: tb/tb_mux4_1.sv
// Self-checking bench for mux4_1 at LANE_W=1 and LANE_W=8.
// Expected lanes are queued at drive time and popped at output time.
module tb_mux4_1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  d1;
  logic [1:0]  s1;
  logic        v1;
  logic        y1;
  logic        ov1;
  logic [31:0] d8;
  logic [1:0]  s8;
  logic        v8;
  logic [7:0]  y8;
  logic        ov8;

  int checks = 0;
  int errors = 0;

  logic [7:0] q1[$];
  logic [7:0] q8[$];

  always #5 clk = ~clk;

  mux4_1 #(.LANE_W(1)) u_n (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_in  (d1),
    .sel_in   (s1),
    .in_valid (v1),
    .y_out    (y1),
    .out_valid(ov1)
  );

  mux4_1 #(.LANE_W(8)) u_w (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_in  (d8),
    .sel_in   (s8),
    .in_valid (v8),
    .y_out    (y8),
    .out_valid(ov8)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1);
  end

  task automatic test_reset;
    rst_n = 1'b0;
    v1 = 0; d1 = '0; s1 = '0;
    v8 = 0; d8 = '0; s8 = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (y1 !== 1'b0 || ov1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_n: got y=%b v=%b exp 0 0", y1, ov1);
    end
    checks++;
    if (y8 !== 8'h00 || ov8 !== 1'b0) begin
      errors++;
      $display("FAIL reset_w: got y=%h v=%b exp 00 0", y8, ov8);
    end
  endtask

  task automatic test_release;
    logic [7:0] e;
    @(negedge clk);
    rst_n = 1'b1;
    d1 = 4'b0010; s1 = 2'd1; v1 = 1'b1;
    @(negedge clk);
    checks++;
    if (ov1 !== 1'b0) begin
      errors++;
      $display("FAIL release_edge1: got v=%b exp 0", ov1);
    end
    q1.push_back({7'd0, d1[s1]});
    @(negedge clk);
    e = q1.pop_front();
    checks++;
    if (ov1 !== 1'b1 || y1 !== e[0]) begin
      errors++;
      $display("FAIL release_edge2: got y=%b v=%b exp %b 1", y1, ov1, e[0]);
    end
    v1 = 1'b0;
  endtask

  task automatic test_reset_async;
    @(negedge clk);
    d1 = 4'b1111; s1 = 2'd0; v1 = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (y1 !== 1'b1 || ov1 !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: got y=%b v=%b exp 1 1", y1, ov1);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (y1 !== 1'b0 || ov1 !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got y=%b v=%b exp 0 0", y1, ov1);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (y1 !== 1'b0 || ov1 !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold%0d: got y=%b v=%b exp 0 0", i, y1, ov1);
      end
    end
    q1.delete();
    v1 = 1'b0;
  endtask

  task automatic test_sweep;
    logic [3:0] dv;
    logic [7:0] e;
    for (int s = 0; s < 4; s++) begin
      for (int d = 0; d < 16; d++) begin
        @(negedge clk);
        if (q1.size() > 0) begin
          e = q1.pop_front();
          checks++;
          if (y1 !== e[0] || ov1 !== 1'b1) begin
            errors++;
            $display("FAIL sweep: got y=%b v=%b exp %b 1", y1, ov1, e[0]);
          end
        end
        dv = 4'(d);
        d1 = dv; s1 = 2'(s); v1 = 1'b1;
        q1.push_back({7'd0, dv[s]});
      end
    end
    @(negedge clk);
    e = q1.pop_front();
    checks++;
    if (y1 !== e[0] || ov1 !== 1'b1) begin
      errors++;
      $display("FAIL sweep_last: got y=%b v=%b exp %b 1", y1, ov1, e[0]);
    end
    v1 = 1'b0;
  endtask

  task automatic test_hold;
    logic [7:0] e;
    @(negedge clk);
    d1 = 4'b1000; s1 = 2'd3; v1 = 1'b1;
    q1.push_back(8'd1);
    @(negedge clk);
    e = q1.pop_front();
    checks++;
    if (y1 !== e[0] || ov1 !== 1'b1) begin
      errors++;
      $display("FAIL hold_accept: got y=%b v=%b exp %b 1", y1, ov1, e[0]);
    end
    v1 = 1'b0; d1 = '0; s1 = '0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (y1 !== 1'b1 || ov1 !== 1'b0) begin
        errors++;
        $display("FAIL hold_idle%0d: got y=%b v=%b exp 1 0", i, y1, ov1);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] e;
    d8 = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (q8.size() > 0) begin
        e = q8.pop_front();
        checks++;
        if (y8 !== e || ov8 !== 1'b1) begin
          errors++;
          $display("FAIL wide_b2b: got y=%h v=%b exp %h 1", y8, ov8, e);
        end
      end
      if (k < 4) begin
        s8 = 2'(k); v8 = 1'b1;
        q8.push_back(d8[k*8 +: 8]);
      end else begin
        v8 = 1'b0;
      end
    end
    @(negedge clk);
    checks++;
    if (ov8 !== 1'b0 || y8 !== 8'hD4) begin
      errors++;
      $display("FAIL wide_idle: got y=%h v=%b exp d4 0", y8, ov8);
    end
  endtask

  task automatic test_reset_midstream;
    logic [7:0] e;
    @(negedge clk);
    d1 = 4'b0100; s1 = 2'd2; v1 = 1'b1;
    q1.push_back(8'd1);
    @(negedge clk);
    e = q1.pop_front();
    checks++;
    if (y1 !== e[0] || ov1 !== 1'b1) begin
      errors++;
      $display("FAIL mid_accept: got y=%b v=%b exp %b 1", y1, ov1, e[0]);
    end
    d1 = 4'b1011; s1 = 2'd0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (y1 !== 1'b0 || ov1 !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got y=%b v=%b exp 0 0", y1, ov1);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (ov1 !== 1'b0 || y1 !== 1'b0) begin
        errors++;
        $display("FAIL mid_drop%0d: got y=%b v=%b exp 0 0", i, y1, ov1);
      end
    end
    v1 = 1'b0;
    test_release();
  endtask

  task automatic test_x_sel;
    @(negedge clk);
    d1 = 4'b1111; s1 = 2'd0; v1 = 1'b1;
    @(negedge clk);
    checks++;
    if (y1 !== 1'b1 || ov1 !== 1'b1) begin
      errors++;
      $display("FAIL x_prime: got y=%b v=%b exp 1 1", y1, ov1);
    end
    d1 = 4'b0000; s1 = 2'bxx;
    @(negedge clk);
    checks++;
    if (y1 !== 1'b0 || ov1 !== 1'b1) begin
      errors++;
      $display("FAIL x_sel: got y=%b v=%b exp 0 1", y1, ov1);
    end
    v1 = 1'b0; s1 = 2'd0;
  endtask

  initial begin
    test_reset();
    test_release();
    test_reset_async();
    test_release();
    test_sweep();
    test_hold();
    test_back_to_back();
    test_reset_midstream();
    test_x_sel();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
